conv_host: RTL and testbench

CONV_HOST -- requirements
Module: conv_host

---
 rtl/conv_host_pkg.sv | 26 ++
 rtl/conv_host_fifo2.sv | 49 ++++
 rtl/conv_host.sv | 166 ++++++++++++++++
 tb/tb_conv_host.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_host_pkg.sv
// Shared definitions for the convolution host controller: sequencing states,
// image/layer geometry, data and address widths, and layer-memory bank codes.
// No ports; imported by conv_host and conv_host_fifo2.
package conv_host_pkg;

  localparam int IMG_WORDS = 4096;
  localparam int DATA_W    = 20;
  localparam int ADDR_W    = 12;

  localparam logic [2:0] CSEL_B1 = 3'b001;
  localparam logic [2:0] CSEL_B2 = 3'b010;
  localparam logic [2:0] CSEL_B3 = 3'b011;
  localparam logic [2:0] CSEL_B4 = 3'b100;
  localparam logic [2:0] CSEL_B5 = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/conv_host_fifo2.sv
// Two-entry result FIFO between the layer-memory read port and the output stream.
// Latency: a push is visible at head_o the cycle after; push when full / pop when empty are dropped.
// Ports: clk/reset (async high), push_i + push_dat_i, pop_i, head_o, empty_o, full_o.
module conv_host_fifo2
  import conv_host_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/conv_host.sv
// Host sequencer: loads a 4096-word image, handshakes the convolution engine, then drains one layer bank.
// Latency: image words written same cycle; first result 2 cycles after drain starts, then 1 word/cycle.
// Backpressure: img_ready only in LOAD; out_ready stalls the 2-entry FIFO and throttles layer reads.
// Ports: start/done/err control, img_* stream in, im_* image write, ready/busy engine handshake,
//        crd/caddr_rd/csel/cdata_rd layer read, out_* result stream.
module conv_host
  import conv_host_pkg::*;
#(
  parameter logic [2:0] OUT_SEL     = CSEL_B5,
  parameter int         OUT_WORDS   = 2048,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              err,
  input  logic              img_valid,
  input  logic [DATA_W-1:0] img_data,
  output logic              img_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              ready,
  input  logic              busy,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [2:0]        csel,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  // One extra bit so OUT_WORDS = 4096 can be counted to completion.
  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              busy_q;
  logic              crd_q;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_pop;
  logic [1:0]        fifo_occ;
  logic [1:0]        occ_budget;

  conv_host_fifo2 u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (crd_q),
    .push_dat_i (cdata_rd),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_head : '0;
  assign out_last  = out_valid && (pop_cnt_q == CNT_W'(OUT_WORDS - 1));
  assign fifo_pop  = out_valid && out_ready;

  assign fifo_occ   = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  // Occupancy after this cycle's pop plus the read returning next cycle. Counting the
  // pop lets a read issue every cycle while the consumer keeps up.
  assign occ_budget = fifo_occ - {1'b0, fifo_pop} + {1'b0, crd_q};

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    pop_cnt_d  = pop_cnt_q;
    tmo_d      = '0;
    img_ready  = 1'b0;
    im_we      = 1'b0;
    im_addr    = '0;
    im_wdata   = '0;
    ready      = 1'b0;
    crd        = 1'b0;
    caddr_rd   = '0;
    csel       = '0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_cnt_d = '0;
        rd_cnt_d   = '0;
        pop_cnt_d  = '0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        img_ready = 1'b1;
        im_addr   = load_cnt_q;
        if (img_valid) begin
          im_we      = 1'b1;
          im_wdata   = img_data;
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == ADDR_W'(IMG_WORDS - 1)) state_d = S_START;
        end
      end
      S_START: begin
        ready = 1'b1;
        if (busy) begin
          state_d = S_RUN;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RUN: begin
        if (busy_q && !busy) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        csel     = OUT_SEL;
        caddr_rd = rd_cnt_q[ADDR_W-1:0];
        // The explicit !full term keeps a read from issuing while two words sit in the FIFO.
        if ((rd_cnt_q < CNT_W'(OUT_WORDS)) && !fifo_full && (occ_budget < 2'd2)) begin
          crd      = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (fifo_pop) begin
          pop_cnt_d = pop_cnt_q + 1'b1;
          if (out_last) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      rd_cnt_q   <= '0;
      pop_cnt_q  <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      crd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy;
      crd_q      <= crd;
    end
  end

endmodule

// File: tb/tb_conv_host.sv
// Self-checking bench for conv_host: randomized image loads, engine handshakes,
// drains under output backpressure, timeout and asynchronous reset.
module tb_conv_host;

  localparam int         IMG   = 4096;
  localparam int         NOUT  = 2048;
  localparam logic [2:0] BANK  = 3'b101;
  localparam int         LIMIT = 20000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        done;
  logic        err;
  logic        img_valid;
  logic [19:0] img_data;
  logic        img_ready;
  logic        im_we;
  logic [11:0] im_addr;
  logic [19:0] im_wdata;
  logic        ready;
  logic        busy;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [2:0]  csel;
  logic [19:0] cdata_rd;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_last;
  logic        out_ready;

  int n_vec = 0;
  int n_bad = 0;
  int rdy_mode = 0;
  int rdy_ph = 0;
  int n_pop_total = 0;

  conv_host #(.OUT_SEL(BANK), .OUT_WORDS(NOUT), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .err(err),
    .img_valid(img_valid), .img_data(img_data), .img_ready(img_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .ready(ready), .busy(busy),
    .crd(crd), .caddr_rd(caddr_rd), .csel(csel), .cdata_rd(cdata_rd),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_img_ready"}, img_ready, 0);
    chk({tag, "_im_we"}, im_we, 0);
    chk({tag, "_im_addr"}, im_addr, 0);
    chk({tag, "_im_wdata"}, im_wdata, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_crd"}, crd, 0);
    chk({tag, "_caddr_rd"}, caddr_rd, 0);
    chk({tag, "_csel"}, csel, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Layer memory: word at address a holds a+7, returned the cycle after the read;
  // garbage is driven on cycles with no read outstanding.
  logic        mem_pend;
  logic [11:0] mem_addr;
  initial begin
    cdata_rd = '0;
    forever begin
      @(negedge clk);
      mem_pend = crd;
      mem_addr = caddr_rd;
      @(posedge clk);
      #1;
      cdata_rd = mem_pend ? (20'(mem_addr) + 20'd7) : 20'($urandom);
    end
  end

  // Output consumer: always ready, or the repeating 1,0,0,1 pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : ((rdy_ph % 4 == 0) || (rdy_ph % 4 == 3));
      rdy_ph++;
    end
  end

  // Result-stream scoreboard: words held = reads returned (two cycles after crd) minus pops.
  int   held = 0;
  int   pop_idx = 0;
  bit   c1 = 0, c2 = 0, last_pop = 0, last_stall = 0;
  logic [19:0] last_dat = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 0; pop_idx = 0; c1 = 0; c2 = 0; last_pop = 0; last_stall = 0;
      end else begin
        held = held + int'(c2) - int'(last_pop);
        chk("out_valid_vs_held", out_valid, held != 0);
        chk("crd_with_2_held", crd && (held >= 2), 0);
        if (last_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, last_dat);
        end
        if (out_valid && out_ready) begin
          chk("out_data", out_data, pop_idx + 7);
          chk("out_last", out_last, pop_idx == NOUT - 1);
          n_pop_total++;
          pop_idx = (pop_idx == NOUT - 1) ? 0 : pop_idx + 1;
        end
        c2 = c1;
        c1 = crd;
        last_pop   = out_valid && out_ready;
        last_stall = out_valid && !out_ready;
        last_dat   = out_data;
      end
    end
  end

  // All tasks below start and end just after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_load(input bit rnd, input int nwords);
    int n = 0;
    int cyc = 0;
    while (n < nwords && cyc < LIMIT) begin
      img_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      img_data  = rnd ? 20'($urandom) : 20'(n);
      @(negedge clk);
      chk("load_img_ready", img_ready, 1);
      chk("load_im_we", im_we, img_valid);
      chk("load_ready", ready, 0);
      if (img_valid) begin
        chk("load_im_addr", im_addr, n);
        chk("load_im_wdata", im_wdata, img_data);
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    img_valid = 1'b0;
    chk("load_words", n, nwords);
  endtask

  task automatic do_job(input bit rnd, input int busy_dly, input bit poke, input bit exact);
    int base;
    int d = 0, ndone = 0, post = 0, first_v = -1;
    base = n_pop_total;
    pulse_start();
    do_load(rnd, IMG);
    for (int i = 0; i < busy_dly; i++) begin
      @(negedge clk);
      chk("start_ready", ready, 1);
      chk("start_img_ready", img_ready, 0);
      @(posedge clk); #1;
    end
    busy = 1'b1;
    @(negedge clk);
    chk("ack_ready", ready, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      if (poke) begin
        start = (i % 7 == 0);
        img_valid = 1'b1;
      end
      @(negedge clk);
      chk("run_ready", ready, 0);
      chk("run_img_ready", img_ready, 0);
      chk("run_im_we", im_we, 0);
      chk("run_crd", crd, 0);
      chk("run_csel", csel, 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    img_valid = 1'b0;
    busy = 1'b0;
    while (d < LIMIT && post < 3) begin
      start = poke && (ndone == 0) && (d % 5 == 1);
      @(negedge clk);
      if (d == 1) begin
        chk("drain_first_crd", crd, 1);
        chk("drain_first_addr", caddr_rd, 0);
      end
      if (out_valid && first_v < 0) first_v = d;
      if (done) begin
        ndone++;
        if (exact) chk("done_cycle", d, 2051);
      end else if (ndone > 0) begin
        post++;
      end
      if (d >= 1 && ndone == 0 && !done) chk("drain_csel", csel, BANK);
      if (d == 0 || ndone > 0) chk("nondrain_crd", crd, 0);
      @(posedge clk); #1;
      d++;
    end
    start = 1'b0;
    chk("done_pulses", ndone, 1);
    chk("first_out_valid", first_v, 3);
    chk("words_popped", n_pop_total - base, NOUT);
    @(negedge clk);
    chk("after_done_img_ready", img_ready, 0);
    chk("after_done_ready", ready, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    reset = 1'b1;
    start = 1'b0;
    img_valid = 1'b1;
    img_data = 20'hABCDE;
    busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    zero_check("in_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    img_valid = 1'b0;
    @(negedge clk);
    zero_check("post_reset");
    @(posedge clk); #1;

    // Ramp load, busy 3 cycles after ready, consumer always ready.
    do_job(1'b0, 3, 1'b0, 1'b1);

    // Random load, random ack delay, 1,0,0,1 consumer, start/img_valid pokes.
    rdy_mode = 1;
    do_job(1'b1, int'($urandom_range(0, 15)), 1'b1, 1'b0);
    rdy_mode = 0;

    // Reset in the middle of a load.
    pulse_start();
    do_load(1'b0, 1000);
    img_valid = 1'b1;
    img_data = 20'd1000;
    reset = 1'b1;
    #1;
    zero_check("mid_load_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    img_valid = 1'b0;
    @(negedge clk);
    zero_check("after_mid_reset");
    @(posedge clk); #1;

    // Reload from address 0, then the engine never acknowledges.
    pulse_start();
    do_load(1'b1, IMG);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (!ready) break;
      k++;
      @(posedge clk); #1;
    end
    chk("timeout_cycles", k, 16);
    chk("timeout_err", err, 1);
    chk("timeout_ready", ready, 0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    img_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("err_sticky", err, 1);
      chk("err_img_ready", img_ready, 0);
      chk("err_im_we", im_we, 0);
      chk("err_ready", ready, 0);
      @(posedge clk); #1;
    end
    img_valid = 1'b0;
    reset = 1'b1;
    #1;
    zero_check("err_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("err_cleared", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
